simd_decode_queue: RTL and testbench

- Parametrised successor to the combinational SIMD decoder.
- Buffers fetched 32-bit instructions with a per-instruction lane mask in a FIFO and decodes the head entry.
- Presents registered decode results to the SIMD dispatch stage over a valid/ready handshake.
- Adds immediate ops (ADDI/SUBI), an explicit RET, illegal-op detection, a halt-on-RET state machine and decode/illegal counters.

---
 rtl/simd_pkg.sv | 75 +++++++
 rtl/simd_instr_fifo.sv | 44 ++++
 rtl/simd_decode_queue.sv | 157 +++++++++++++++
 tb/tb_simd_decode_queue.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types and the instruction decoder for the SIMD decode queue.
// The queue's push side and its output stage both decode through this package.
package simd_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_MUL     = 4'd2,
        OP_UDIV    = 4'd3,
        OP_FADD    = 4'd4,
        OP_FSUB    = 4'd5,
        OP_LOAD    = 4'd6,
        OP_RET     = 4'd7,
        OP_ADDI    = 4'd8,
        OP_SUBI    = 4'd9,
        OP_ILLEGAL = 4'd15
    } op_e;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_e;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_MUL  = 11'b10011011000;
    localparam logic [10:0] OPC_UDIV = 11'b10011010110;
    localparam logic [10:0] OPC_FP   = 11'b00011110011;
    localparam logic [10:0] OPC_LOAD = 11'b10101010101;
    localparam logic [10:0] OPC_RET  = 11'b11010110010;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [5:0]  FUNC_FADD = 6'b001010;
    localparam logic [5:0]  FUNC_FSUB = 6'b001110;

    // Address is kept at its widest (9 bits); the top trims it to ADDR_W.
    typedef struct packed {
        op_e        op;
        logic [4:0] regnum_1;
        logic [4:0] regnum_2;
        logic [4:0] dest_reg;
        logic [5:0] shammt;
        logic [8:0] address;
        logic [11:0] immediate;
    } decoded_t;

    function automatic op_e decode_op(input logic [31:0] instr);
        op_e op;
        if (instr[31:21] == OPC_ADD)                                   op = OP_ADD;
        else if (instr[31:21] == OPC_SUB)                              op = OP_SUB;
        else if (instr[31:21] == OPC_MUL)                              op = OP_MUL;
        else if (instr[31:21] == OPC_UDIV)                             op = OP_UDIV;
        else if (instr[31:21] == OPC_FP && instr[15:10] == FUNC_FADD)  op = OP_FADD;
        else if (instr[31:21] == OPC_FP && instr[15:10] == FUNC_FSUB)  op = OP_FSUB;
        else if (instr[31:21] == OPC_LOAD)                             op = OP_LOAD;
        else if (instr[31:21] == OPC_RET)                              op = OP_RET;
        else if (instr[31:22] == OPC_ADDI)                             op = OP_ADDI;
        else if (instr[31:22] == OPC_SUBI)                             op = OP_SUBI;
        else                                                           op = OP_ILLEGAL;
        return op;
    endfunction

    function automatic decoded_t decode(input logic [31:0] instr);
        decoded_t d;
        d.op        = decode_op(instr);
        d.regnum_1  = instr[9:5];
        d.regnum_2  = instr[20:16];
        d.dest_reg  = instr[4:0];
        d.shammt    = instr[15:10];
        d.address   = instr[20:12];
        d.immediate = (d.op == OP_ADDI || d.op == OP_SUBI) ? instr[21:10] : 12'd0;
        return d;
    endfunction

endpackage

// File: rtl/simd_instr_fifo.sv
// Synchronous FIFO of {lane_mask, instruction}; head is read combinationally
// so an entry pushed in one cycle can be popped the next.
module simd_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // The extra MSB separates a full ring from an empty one.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/simd_decode_queue.sv
// Instruction queue with registered decode output, halt-on-RET control and
// decode/illegal counters feeding the SIMD dispatch stage.
module simd_decode_queue
    import simd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LANES      = 4,
    parameter int ADDR_W     = 9,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [LANES-1:0]  in_lane_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        type_instruction,
    output logic [4:0]        regnum_1,
    output logic [4:0]        regnum_2,
    output logic [4:0]        dest_reg,
    output logic [5:0]        shammt,
    output logic [ADDR_W-1:0] address,
    output logic [11:0]       immediate,
    output logic [LANES-1:0]  lane_mask,
    output logic              illegal,
    output logic              halted,
    input  logic              resume,
    output logic [CNT_W-1:0]  decoded_count,
    output logic [CNT_W-1:0]  illegal_count
);
    logic [31+LANES:0] head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              load;
    logic              handshake;
    logic              push_is_ret;
    decoded_t          head_dec;

    state_e            state_reg;
    logic              halted_reg;
    logic              out_valid_reg;
    op_e               type_reg;
    logic [4:0]        regnum_1_reg;
    logic [4:0]        regnum_2_reg;
    logic [4:0]        dest_reg_reg;
    logic [5:0]        shammt_reg;
    logic [ADDR_W-1:0] address_reg;
    logic [11:0]       immediate_reg;
    logic [LANES-1:0]  lane_mask_reg;
    logic              illegal_reg;
    logic [CNT_W-1:0]  decoded_count_reg;
    logic [CNT_W-1:0]  illegal_count_reg;

    assign in_ready    = !rst && !fifo_full && (state_reg == ST_RUN);
    assign push        = in_valid && in_ready;
    assign load        = !fifo_empty && (!out_valid_reg || out_ready);
    assign handshake   = out_valid_reg && out_ready;
    assign push_is_ret = (decode_op(instruction) == OP_RET);
    assign head_dec    = decode(head_data[31:0]);

    simd_instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32 + LANES)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (load),
        .wr_data ({in_lane_mask, instruction}),
        .rd_data (head_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A RET halts intake once it is queued; queued work keeps draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_RUN;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (push && push_is_ret) begin
                        state_reg  <= ST_HALTED;
                        halted_reg <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state_reg  <= ST_RUN;
                        halted_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= ST_RUN;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg     <= 1'b0;
            type_reg          <= OP_ADD;
            regnum_1_reg      <= '0;
            regnum_2_reg      <= '0;
            dest_reg_reg      <= '0;
            shammt_reg        <= '0;
            address_reg       <= '0;
            immediate_reg     <= '0;
            lane_mask_reg     <= '0;
            illegal_reg       <= 1'b0;
            decoded_count_reg <= '0;
            illegal_count_reg <= '0;
        end else begin
            if (load) begin
                out_valid_reg <= 1'b1;
                type_reg      <= head_dec.op;
                regnum_1_reg  <= head_dec.regnum_1;
                regnum_2_reg  <= head_dec.regnum_2;
                dest_reg_reg  <= head_dec.dest_reg;
                shammt_reg    <= head_dec.shammt;
                address_reg   <= head_dec.address[ADDR_W-1:0];
                immediate_reg <= head_dec.immediate;
                lane_mask_reg <= head_data[31+LANES:32];
                illegal_reg   <= (head_dec.op == OP_ILLEGAL);
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (handshake) begin
                decoded_count_reg <= decoded_count_reg + 1'b1;
            end
            if (handshake && illegal_reg && (illegal_count_reg != '1)) begin
                illegal_count_reg <= illegal_count_reg + 1'b1;
            end
        end
    end

    assign out_valid        = out_valid_reg;
    assign type_instruction = type_reg;
    assign regnum_1         = regnum_1_reg;
    assign regnum_2         = regnum_2_reg;
    assign dest_reg         = dest_reg_reg;
    assign shammt           = shammt_reg;
    assign address          = address_reg;
    assign immediate        = immediate_reg;
    assign lane_mask        = lane_mask_reg;
    assign illegal          = illegal_reg;
    assign halted           = halted_reg;
    assign decoded_count    = decoded_count_reg;
    assign illegal_count    = illegal_count_reg;

endmodule

// File: tb/tb_simd_decode_queue.sv
// Directed bench for simd_decode_queue; a second instance with 2-bit counters
// shares the stimulus to exercise counter wrap and saturation.
module tb_simd_decode_queue;
    localparam int LANES  = 4;
    localparam int ADDR_W = 9;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic [LANES-1:0]  in_lane_mask;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        type_instruction;
    logic [4:0]        regnum_1;
    logic [4:0]        regnum_2;
    logic [4:0]        dest_reg;
    logic [5:0]        shammt;
    logic [ADDR_W-1:0] address;
    logic [11:0]       immediate;
    logic [LANES-1:0]  lane_mask;
    logic              illegal;
    logic              halted;
    logic              resume;
    logic [15:0]       decoded_count;
    logic [15:0]       illegal_count;

    logic              in_ready_s;
    logic              out_valid_s;
    logic [3:0]        type_s;
    logic [4:0]        regnum_1_s;
    logic [4:0]        regnum_2_s;
    logic [4:0]        dest_reg_s;
    logic [5:0]        shammt_s;
    logic [ADDR_W-1:0] address_s;
    logic [11:0]       immediate_s;
    logic [LANES-1:0]  lane_mask_s;
    logic              illegal_s;
    logic              halted_s;
    logic [1:0]        decoded_count_s;
    logic [1:0]        illegal_count_s;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] obs_type [$];
    logic [4:0] obs_dest [$];
    logic [3:0] obs_mask [$];

    simd_decode_queue #(.FIFO_DEPTH(4), .LANES(LANES), .ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .in_lane_mask(in_lane_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .type_instruction(type_instruction), .regnum_1(regnum_1), .regnum_2(regnum_2),
        .dest_reg(dest_reg), .shammt(shammt), .address(address), .immediate(immediate),
        .lane_mask(lane_mask), .illegal(illegal), .halted(halted), .resume(resume),
        .decoded_count(decoded_count), .illegal_count(illegal_count)
    );

    simd_decode_queue #(.FIFO_DEPTH(4), .LANES(LANES), .ADDR_W(ADDR_W), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .instruction(instruction), .in_lane_mask(in_lane_mask),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .type_instruction(type_s), .regnum_1(regnum_1_s), .regnum_2(regnum_2_s),
        .dest_reg(dest_reg_s), .shammt(shammt_s), .address(address_s), .immediate(immediate_s),
        .lane_mask(lane_mask_s), .illegal(illegal_s), .halted(halted_s), .resume(resume),
        .decoded_count(decoded_count_s), .illegal_count(illegal_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records each handshake half a cycle ahead of the edge that completes it.
    always @(negedge clk) begin
        if (rst) begin
            obs_type.delete();
            obs_dest.delete();
            obs_mask.delete();
        end else if (out_valid && out_ready) begin
            obs_type.push_back(type_instruction);
            obs_dest.push_back(dest_reg);
            obs_mask.push_back(lane_mask);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; resume = 1'b0;
        instruction = 32'd0; in_lane_mask = '0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [LANES-1:0] m);
        int n;
        n = 0;
        instruction = ins; in_lane_mask = m; in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        check_vec("push_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check_vec("wait_valid", {31'd0, out_valid}, 32'd1);
    endtask

    logic [31:0] tbl_ins  [11];
    logic [3:0]  tbl_type [11];
    logic [11:0] tbl_imm  [11];
    logic [8:0]  tbl_addr [11];

    initial begin
        logic [31:0] w;

        tbl_ins  = '{32'h8B000000, 32'hCB000000, 32'h9B000000, 32'h9AC00000, 32'h1E602800,
                     32'h1E603800, 32'h1E600000, 32'hAAB3F000, 32'h91000000, 32'hD13FFC00,
                     32'h91200000};
        tbl_type = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15, 4'd6, 4'd8, 4'd9, 4'd8};
        tbl_imm  = '{12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'hFFF, 12'h800};
        tbl_addr = '{9'h0, 9'h0, 9'h0, 9'h0, 9'h2, 9'h3, 9'h0, 9'h13F, 9'h0, 9'h1FF, 9'h0};

        // Reset state
        do_reset();
        check_vec("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_vec("rst_halted", {31'd0, halted}, 32'd0);
        check_vec("rst_decoded_count", {16'd0, decoded_count}, 32'd0);
        check_vec("rst_illegal_count", {16'd0, illegal_count}, 32'd0);
        check_vec("rst_type", {28'd0, type_instruction}, 32'd0);
        check_vec("rst_in_ready_after", {31'd0, in_ready}, 32'd1);

        // ADD latency: push in cycle 0, result in cycle 2
        out_ready = 1'b1;
        instruction = 32'h8B020023; in_lane_mask = 4'hF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_vec("add_lat_cycle1", {31'd0, out_valid}, 32'd0);
        step();
        check_vec("add_valid", {31'd0, out_valid}, 32'd1);
        check_vec("add_type", {28'd0, type_instruction}, 32'd0);
        check_vec("add_rn1", {27'd0, regnum_1}, 32'd1);
        check_vec("add_rn2", {27'd0, regnum_2}, 32'd2);
        check_vec("add_dest", {27'd0, dest_reg}, 32'd3);
        check_vec("add_imm", {20'd0, immediate}, 32'd0);
        check_vec("add_addr", {23'd0, address}, 32'd32);
        check_vec("add_mask", {28'd0, lane_mask}, 32'hF);
        check_vec("add_illegal", {31'd0, illegal}, 32'd0);
        step();
        check_vec("add_count", {16'd0, decoded_count}, 32'd1);
        check_vec("add_valid_after", {31'd0, out_valid}, 32'd0);

        // ADDI then FADD back to back
        do_reset();
        out_ready = 1'b1;
        push(32'h910190C5, 4'h0);
        push(32'h1E622820, 4'hA);
        check_vec("addi_type", {28'd0, type_instruction}, 32'd8);
        check_vec("addi_rn1", {27'd0, regnum_1}, 32'd6);
        check_vec("addi_dest", {27'd0, dest_reg}, 32'd5);
        check_vec("addi_imm", {20'd0, immediate}, 32'd100);
        check_vec("addi_mask_zero", {28'd0, lane_mask}, 32'h0);
        step();
        check_vec("fadd_valid", {31'd0, out_valid}, 32'd1);
        check_vec("fadd_type", {28'd0, type_instruction}, 32'd4);
        check_vec("fadd_rn2", {27'd0, regnum_2}, 32'd2);
        check_vec("fadd_rn1", {27'd0, regnum_1}, 32'd1);
        check_vec("fadd_shammt", {26'd0, shammt}, 32'h0A);
        check_vec("fadd_imm", {20'd0, immediate}, 32'd0);
        check_vec("fadd_mask", {28'd0, lane_mask}, 32'hA);
        step();
        check_vec("addi_fadd_count", {16'd0, decoded_count}, 32'd2);

        // Opcode table
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            push(tbl_ins[i], 4'h5);
            wait_valid();
            check_vec($sformatf("tbl%0d_type", i), {28'd0, type_instruction}, {28'd0, tbl_type[i]});
            check_vec($sformatf("tbl%0d_illegal", i), {31'd0, illegal}, {31'd0, (tbl_type[i] == 4'd15)});
            check_vec($sformatf("tbl%0d_imm", i), {20'd0, immediate}, {20'd0, tbl_imm[i]});
            check_vec($sformatf("tbl%0d_addr", i), {23'd0, address}, {23'd0, tbl_addr[i]});
            step();
        end
        check_vec("tbl_decoded_count", {16'd0, decoded_count}, 32'd11);
        check_vec("tbl_illegal_count", {16'd0, illegal_count}, 32'd1);

        // Backpressure: output register plus 4 queued entries fill the pipe
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = 32'h8B000000 | 32'(i << 5) | 32'(i + 1);
            push(w, 4'(i));
        end
        check_vec("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check_vec("bp_stall_valid", {31'd0, out_valid}, 32'd1);
            check_vec("bp_stall_dest", {27'd0, dest_reg}, 32'd1);
            check_vec("bp_stall_rn1", {27'd0, regnum_1}, 32'd0);
            check_vec("bp_stall_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        check_vec("bp_out_count", obs_dest.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_vec($sformatf("bp_order%0d_dest", i), {27'd0, obs_dest[i]}, 32'(i + 1));
            check_vec($sformatf("bp_order%0d_mask", i), {28'd0, obs_mask[i]}, 32'(i));
        end
        check_vec("bp_decoded_count", {16'd0, decoded_count}, 32'd5);

        // RET halts intake until resume
        do_reset();
        out_ready = 1'b1;
        push(32'h8B000001, 4'hF);
        push(32'hD65F03C0, 4'hF);
        check_vec("ret_halted", {31'd0, halted}, 32'd1);
        check_vec("ret_in_ready", {31'd0, in_ready}, 32'd0);
        instruction = 32'h8B000007; in_lane_mask = 4'hF; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_vec("ret_blocked", {31'd0, in_ready}, 32'd0);
        end
        check_vec("ret_drained", obs_type.size(), 32'd2);
        check_vec("ret_first_type", {28'd0, obs_type[0]}, 32'd0);
        check_vec("ret_second_type", {28'd0, obs_type[1]}, 32'd7);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check_vec("resume_halted", {31'd0, halted}, 32'd0);
        check_vec("resume_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check_vec("resume_out_count", obs_dest.size(), 32'd3);
        check_vec("resume_out_dest", {27'd0, obs_dest[2]}, 32'd7);
        instruction = 32'hD65F03C0; in_valid = 1'b1; resume = 1'b1;
        step();
        in_valid = 1'b0; resume = 1'b0;
        check_vec("ret_with_resume_halted", {31'd0, halted}, 32'd1);
        for (int k = 0; k < 3; k++) step();
        check_vec("ret_decoded_count", {16'd0, decoded_count}, 32'd4);

        // Illegal ops and saturating counter
        do_reset();
        out_ready = 1'b1;
        push(32'h00000000, 4'hF);
        wait_valid();
        check_vec("ill1_type", {28'd0, type_instruction}, 32'd15);
        check_vec("ill1_flag", {31'd0, illegal}, 32'd1);
        step();
        push(32'h00000000, 4'hF);
        wait_valid();
        check_vec("ill2_flag", {31'd0, illegal}, 32'd1);
        step();
        step();
        check_vec("ill_count2", {16'd0, illegal_count}, 32'd2);
        check_vec("ill_count2_small", {30'd0, illegal_count_s}, 32'd2);
        for (int k = 0; k < 3; k++) push(32'h00000000, 4'hF);
        for (int k = 0; k < 4; k++) step();
        check_vec("ill_count5", {16'd0, illegal_count}, 32'd5);
        check_vec("ill_count_saturated", {30'd0, illegal_count_s}, 32'd3);
        check_vec("dec_count_wrap_small", {30'd0, decoded_count_s}, 32'd1);
        push(32'h8B000000, 4'hF);
        for (int k = 0; k < 3; k++) step();
        check_vec("ill_sat_hold", {30'd0, illegal_count_s}, 32'd3);
        check_vec("ill_legal_no_inc", {16'd0, illegal_count}, 32'd5);
        check_vec("dec_count6", {16'd0, decoded_count}, 32'd6);

        // Mid-stream reset with entries queued and a halt pending
        do_reset();
        out_ready = 1'b0;
        push(32'h8B000001, 4'hF);
        push(32'h8B000002, 4'hF);
        push(32'h8B000003, 4'hF);
        push(32'hD65F03C0, 4'hF);
        step();
        check_vec("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        check_vec("mid_pre_halted", {31'd0, halted}, 32'd1);
        rst = 1'b1; out_ready = 1'b1;
        step();
        check_vec("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_vec("mid_rst_halted", {31'd0, halted}, 32'd0);
        check_vec("mid_rst_dec", {16'd0, decoded_count}, 32'd0);
        check_vec("mid_rst_ill", {16'd0, illegal_count}, 32'd0);
        check_vec("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check_vec("mid_post_valid", {31'd0, out_valid}, 32'd0);
        end
        check_vec("mid_post_emitted", obs_dest.size(), 32'd0);
        check_vec("mid_post_dec", {16'd0, decoded_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
